// File: rtl/dmem_responder.sv
// Single-port 64-bit data memory slave with a one-deep request/response handshake.
// Latency: the response is presented LATENCY+1 cycles after request acceptance.
// Backpressure: one request in flight; req_ready drops until the response is taken, and resp_ready=0 holds RESP.
//
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   req_valid / req_ready    - request handshake (req_ready is high only in IDLE)
//   req_we, req_wmask        - 1 = store / 0 = load; byte-lane write enables
//   req_addr, req_wdata      - byte address (word index = addr[15:3]); store data
//   resp_valid / resp_ready  - response handshake
//   resp_rdata, resp_err     - load data (0 for stores and errors); index >= DEPTH
module dmem_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [7:0]  req_wmask,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    // The storage is rounded up to a power of two so the array index has an
    // exact width; entries at or above DEPTH are never written or returned.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = 1 << AW;

    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Control and response registers
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_rdata;
    logic        r_err;

    // Request captured at acceptance
    logic        r_we;
    logic [7:0]  r_wmask;
    logic [12:0] r_idx;
    logic [63:0] r_wdata;

    // Storage (deliberately not reset)
    logic [63:0] r_mem [NW];

    // Access-cycle datapath
    logic          w_accept;
    logic          w_access;
    logic          w_acc_we;
    logic [7:0]    w_acc_wmask;
    logic [12:0]   w_acc_idx;
    logic [63:0]   w_acc_wdata;
    logic          w_in_range;
    logic [AW-1:0] w_mem_idx;
    logic [63:0]   w_rd_word;
    logic [63:0]   w_resp_rdata;
    logic          w_unused;

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    assign w_accept = (r_state == IDLE) && req_valid;

    // With zero latency the access happens on the acceptance edge itself,
    // otherwise on the last BUSY cycle.
    assign w_access = (LATENCY == 0) ? w_accept
                                     : ((r_state == BUSY) && (r_cnt == 4'd0));

    // In IDLE the access (zero-latency case) must use the live request, since
    // the capture registers only load on that same edge.
    assign w_acc_we    = (r_state == IDLE) ? req_we         : r_we;
    assign w_acc_wmask = (r_state == IDLE) ? req_wmask      : r_wmask;
    assign w_acc_idx   = (r_state == IDLE) ? req_addr[15:3] : r_idx;
    assign w_acc_wdata = (r_state == IDLE) ? req_wdata      : r_wdata;

    assign w_in_range = (int'({19'd0, w_acc_idx}) < DEPTH);
    assign w_mem_idx  = w_acc_idx[AW-1:0];
    assign w_rd_word  = r_mem[w_mem_idx];

    // Loads return the whole word; stores and out-of-range accesses return 0.
    assign w_resp_rdata = (!w_acc_we && w_in_range) ? w_rd_word : 64'd0;

    // Byte offset within the word plays no part in a 64-bit access.
    assign w_unused = ^req_addr[2:0];

    // Request capture
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_wmask <= req_wmask;
            r_idx   <= req_addr[15:3];
            r_wdata <= req_wdata;
        end
    end

    // Byte-lane store; reset suppresses the write so an abandoned request
    // never reaches the array.
    always_ff @(posedge clk) begin
        if (!rst && w_access && w_acc_we && w_in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (w_acc_wmask[i]) begin
                    r_mem[w_mem_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (LATENCY == 0) begin
                            r_state <= RESP;
                            r_rdata <= w_resp_rdata;
                            r_err   <= !w_in_range;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                        r_rdata <= w_resp_rdata;
                        r_err   <= !w_in_range;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Response fields return to zero once the initiator takes them.
                    if (resp_ready) begin
                        r_state <= IDLE;
                        r_rdata <= 64'd0;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                    r_rdata <= 64'd0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Three responders: dut0 LATENCY=2/DEPTH=16, dut1 LATENCY=0/DEPTH=16, dut2 LATENCY=3/DEPTH=8192.
// Expected responses are queued per instance at issue time; a negedge monitor pops them on each handshake.
// Inputs change 1 time unit after the rising edge; protocol timing is checked from the stimulus thread.
module tb_dmem_responder;

    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [ND-1:0]        rst;
    logic [ND-1:0]        req_valid;
    logic [ND-1:0]        req_ready;
    logic [ND-1:0]        req_we;
    logic [ND-1:0][7:0]   req_wmask;
    logic [ND-1:0][15:0]  req_addr;
    logic [ND-1:0][63:0]  req_wdata;
    logic [ND-1:0]        resp_valid;
    logic [ND-1:0]        resp_ready;
    logic [ND-1:0][63:0]  resp_rdata;
    logic [ND-1:0]        resp_err;

    dmem_responder #(.LATENCY(2), .DEPTH(16)) u_dut0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_wmask(req_wmask[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.LATENCY(0), .DEPTH(16)) u_dut1 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_wmask(req_wmask[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    dmem_responder #(.LATENCY(3)) u_dut2 (
        .clk(clk), .rst(rst[2]),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_wmask(req_wmask[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected {err, rdata} per instance
    logic [64:0] q0[$];
    logic [64:0] q1[$];
    logic [64:0] q2[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int k, input logic e, input logic [63:0] d);
        case (k)
            0: q0.push_back({e, d});
            1: q1.push_back({e, d});
            default: q2.push_back({e, d});
        endcase
    endtask

    // Presents a request and returns once it has been accepted (one cycle after
    // the accepting cycle). acc is the accepting cycle number, -1 on timeout.
    task automatic issue(input int k, input logic we, input logic [7:0] m, input logic [15:0] a,
                         input logic [63:0] d, input logic push, input logic [63:0] er,
                         input logic ee, input logic hold, output int acc);
        int n;
        n = 0;
        if (push) push_exp(k, ee, er);
        req_we[k]    = we;
        req_wmask[k] = m;
        req_addr[k]  = a;
        req_wdata[k] = d;
        req_valid[k] = 1'b1;
        while (req_ready[k] !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        n_cmp++;
        if (req_ready[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL dut%0d_accept: req_ready %b after %0d cycles, required 1", k, req_ready[k], n);
            acc = -1;
            req_valid[k] = 1'b0;
        end else begin
            acc = cyc;
            step();
            if (!hold) req_valid[k] = 1'b0;
        end
    endtask

    // Called one cycle after acceptance; checks first-valid timing and, if
    // resp_ready is high, lets the handshake complete.
    task automatic wait_resp(input int k, input int lat);
        int n;
        n = 1;
        while (resp_valid[k] !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk($sformatf("dut%0d_latency", k), 64'(n), 64'(lat + 1));
        if (resp_valid[k] === 1'b1 && resp_ready[k] === 1'b1) step();
    endtask

    task automatic xact(input int k, input logic we, input logic [7:0] m, input logic [15:0] a,
                        input logic [63:0] d, input logic [63:0] er, input logic ee, input int lat);
        int acc;
        issue(k, we, m, a, d, 1'b1, er, ee, 1'b0, acc);
        if (acc >= 0) wait_resp(k, lat);
    endtask

    always @(negedge clk) begin : monitor
        logic [64:0] e;
        bit          have;
        for (int k = 0; k < ND; k++) begin
            if (resp_valid[k] === 1'b1 && resp_ready[k] === 1'b1) begin
                have = 1'b0;
                e    = '0;
                case (k)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                endcase
                if (!have) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL dut%0d_unexpected_resp: got rdata %h err %b, required no response",
                             k, resp_rdata[k], resp_err[k]);
                end else begin
                    chk($sformatf("dut%0d_resp_rdata", k), resp_rdata[k], e[63:0]);
                    chk($sformatf("dut%0d_resp_err", k), 64'(resp_err[k]), 64'(e[64]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, acc, n;
        rst        = '1;
        req_valid  = '0;
        req_we     = '0;
        req_wmask  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = '1;
        repeat (3) step();
        rst = '0;

        // Reset state of every instance
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("dut%0d_rst_req_ready", k), 64'(req_ready[k]), 64'd1);
            chk($sformatf("dut%0d_rst_resp_valid", k), 64'(resp_valid[k]), 64'd0);
            chk($sformatf("dut%0d_rst_resp_rdata", k), resp_rdata[k], 64'd0);
            chk($sformatf("dut%0d_rst_resp_err", k), 64'(resp_err[k]), 64'd0);
        end

        // ---- dut0: LATENCY=2, DEPTH=16 ----
        xact(0, 1'b1, 8'hFF, 16'h0000, 64'hDEADBEEFCAFEF00D, 64'd0, 1'b0, 2);
        xact(0, 1'b1, 8'hFF, 16'h0010, 64'h1122334455667788, 64'd0, 1'b0, 2);
        xact(0, 1'b0, 8'h00, 16'h0010, 64'd0, 64'h1122334455667788, 1'b0, 2);
        xact(0, 1'b1, 8'h0F, 16'h0010, 64'hAAAAAAAABBBBBBBB, 64'd0, 1'b0, 2);
        xact(0, 1'b0, 8'h00, 16'h0010, 64'd0, 64'h11223344BBBBBBBB, 1'b0, 2);
        // Outer lanes only; low address bits must be ignored
        xact(0, 1'b1, 8'h81, 16'h0013, 64'h5500000000000066, 64'd0, 1'b0, 2);
        xact(0, 1'b0, 8'h00, 16'h0017, 64'd0, 64'h55223344BBBBBB66, 1'b0, 2);
        // Empty mask: response but no change
        xact(0, 1'b1, 8'h00, 16'h0010, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0, 2);
        xact(0, 1'b0, 8'h00, 16'h0010, 64'd0, 64'h55223344BBBBBB66, 1'b0, 2);

        // Stall in RESP for 5 cycles while a competing request is presented
        resp_ready[0] = 1'b0;
        issue(0, 1'b0, 8'h00, 16'h0010, 64'd0, 1'b1, 64'h55223344BBBBBB66, 1'b0, 1'b0, acc);
        wait_resp(0, 2);
        req_we[0]    = 1'b1;
        req_wmask[0] = 8'hFF;
        req_addr[0]  = 16'h0000;
        req_wdata[0] = 64'd0;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_resp_valid", 64'(resp_valid[0]), 64'd1);
            chk("stall_resp_rdata", resp_rdata[0], 64'h55223344BBBBBB66);
            chk("stall_req_ready", 64'(req_ready[0]), 64'd0);
            step();
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        step();
        chk("post_hs_req_ready", 64'(req_ready[0]), 64'd1);
        chk("post_hs_resp_valid", 64'(resp_valid[0]), 64'd0);
        chk("post_hs_resp_rdata", resp_rdata[0], 64'd0);
        // The request presented during the stall must have had no effect
        xact(0, 1'b0, 8'h00, 16'h0000, 64'd0, 64'hDEADBEEFCAFEF00D, 1'b0, 2);

        // Out of range (index 16 aliases index 0 in a 16-entry array)
        xact(0, 1'b0, 8'h00, 16'h0080, 64'd0, 64'd0, 1'b1, 2);
        xact(0, 1'b1, 8'hFF, 16'h0080, 64'h0000000000001234, 64'd0, 1'b1, 2);
        xact(0, 1'b0, 8'h00, 16'h0000, 64'd0, 64'hDEADBEEFCAFEF00D, 1'b0, 2);
        xact(0, 1'b1, 8'hFF, 16'h0078, 64'h0F0E0D0C0B0A0908, 64'd0, 1'b0, 2);
        xact(0, 1'b0, 8'h00, 16'h0078, 64'd0, 64'h0F0E0D0C0B0A0908, 1'b0, 2);
        xact(0, 1'b0, 8'h00, 16'hFFF8, 64'd0, 64'd0, 1'b1, 2);

        // Reset while holding a response: it is dropped
        resp_ready[0] = 1'b0;
        issue(0, 1'b0, 8'h00, 16'h0078, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, acc);
        wait_resp(0, 2);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        resp_ready[0] = 1'b1;
        chk("rst_in_resp_valid", 64'(resp_valid[0]), 64'd0);
        chk("rst_in_resp_req_ready", 64'(req_ready[0]), 64'd1);
        chk("rst_in_resp_rdata", resp_rdata[0], 64'd0);
        chk("rst_in_resp_err", 64'(resp_err[0]), 64'd0);
        xact(0, 1'b0, 8'h00, 16'h0078, 64'd0, 64'h0F0E0D0C0B0A0908, 1'b0, 2);

        // ---- dut1: LATENCY=0, back-to-back requests ----
        xact(1, 1'b1, 8'hFF, 16'h0008, 64'hA5A5A5A55A5A5A5A, 64'd0, 1'b0, 0);
        issue(1, 1'b1, 8'hF0, 16'h0008, 64'h1111111122222222, 1'b1, 64'd0, 1'b0, 1'b1, a1);
        chk("l0_resp_valid_t1_a", 64'(resp_valid[1]), 64'd1);
        chk("l0_req_ready_t1_a", 64'(req_ready[1]), 64'd0);
        step();
        issue(1, 1'b0, 8'h00, 16'h0008, 64'd0, 1'b1, 64'h111111115A5A5A5A, 1'b0, 1'b1, a2);
        chk("l0_spacing_a", 64'(a2 - a1), 64'd2);
        chk("l0_resp_valid_t1_b", 64'(resp_valid[1]), 64'd1);
        chk("l0_req_ready_t1_b", 64'(req_ready[1]), 64'd0);
        step();
        issue(1, 1'b0, 8'h00, 16'h000C, 64'd0, 1'b1, 64'h111111115A5A5A5A, 1'b0, 1'b0, a3);
        chk("l0_spacing_b", 64'(a3 - a2), 64'd2);
        wait_resp(1, 0);

        // ---- dut2: LATENCY=3, reset abandons a pending store ----
        xact(2, 1'b1, 8'hFF, 16'h0008, 64'h0123456789ABCDEF, 64'd0, 1'b0, 3);
        issue(2, 1'b1, 8'hFF, 16'h0008, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'd0, 1'b0, 1'b0, acc);
        rst[2] = 1'b1;
        step();
        rst[2] = 1'b0;
        chk("busy_rst_req_ready", 64'(req_ready[2]), 64'd1);
        chk("busy_rst_resp_valid", 64'(resp_valid[2]), 64'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid[2] === 1'b1) n++;
            step();
        end
        chk("busy_rst_no_resp", 64'(n), 64'd0);
        xact(2, 1'b0, 8'h00, 16'h0008, 64'd0, 64'h0123456789ABCDEF, 1'b0, 3);
        // Top word index is in range at full depth
        xact(2, 1'b1, 8'hFF, 16'hFFF8, 64'h00FF00FF00FF00FF, 64'd0, 1'b0, 3);
        xact(2, 1'b0, 8'h00, 16'hFFFF, 64'd0, 64'h00FF00FF00FF00FF, 1'b0, 3);

        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 20) begin
            step();
            n++;
        end
        chk("queues_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
